// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant counters are enabled with `define ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
`ifdef ALU_ARB_STATS_EN
  ,parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid_i,
  input  logic [2*OP_WIDTH-1:0]   req_op_i,
  input  logic [2*DATA_WIDTH-1:0] req_a_i,
  input  logic [2*DATA_WIDTH-1:0] req_b_i,
  output logic [1:0]              req_ready_o,
  output logic [1:0]              rsp_valid_o,
  input  logic [1:0]              rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_result_o,
  output logic                    rsp_zero_o,
  output logic [OP_WIDTH-1:0]     alu_operation_o,
  output logic [DATA_WIDTH-1:0]   alu_a_o,
  output logic [DATA_WIDTH-1:0]   alu_b_o,
  input  logic [DATA_WIDTH-1:0]   alu_result_i,
  output logic                    busy_o
`ifdef ALU_ARB_STATS_EN
  ,output logic [CNT_WIDTH-1:0]   grant_cnt0_o,
  output logic [CNT_WIDTH-1:0]    grant_cnt1_o
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    ptr, gnt, gnt_q, take, rsp_hs;
  logic [OP_WIDTH-1:0]     op_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    take            = 1'b0;
    rsp_hs          = 1'b0;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    alu_operation_o = '0;
    alu_a_o         = '0;
    alu_b_o         = '0;
    // pointer only breaks ties; a lone requester always wins
    gnt = (req_valid_i == 2'b11) ? ptr : req_valid_i[1];
    case (state)
      IDLE: if (|req_valid_i) begin
        take             = 1'b1;
        req_ready_o[gnt] = 1'b1;
        state_nxt        = EXEC;
      end
      EXEC: begin
        alu_operation_o = op_q;
        alu_a_o         = a_q;
        alu_b_o         = b_q;
        state_nxt       = RESP;
      end
      RESP: begin
        rsp_valid_o[gnt_q] = 1'b1;
        if (rsp_ready_i[gnt_q]) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= 1'b0;
      gnt_q        <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result_o <= '0;
    end else begin
      if (take) begin
        gnt_q <= gnt;
        op_q  <= gnt ? req_op_i[2*OP_WIDTH-1:OP_WIDTH]   : req_op_i[OP_WIDTH-1:0];
        a_q   <= gnt ? req_a_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_a_i[DATA_WIDTH-1:0];
        b_q   <= gnt ? req_b_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_b_i[DATA_WIDTH-1:0];
      end
      if (state == EXEC) rsp_result_o <= alu_result_i;
      if (rsp_hs)        ptr <= ~gnt_q;
    end
  end

  // zero flag is qualified so it never asserts without a response
  assign rsp_zero_o = (state == RESP) && (rsp_result_o == '0);
  assign busy_o     = (state != IDLE);

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_o <= '0;
      grant_cnt1_o <= '0;
    end else if (take) begin
      if (!gnt && grant_cnt0_o != '1) grant_cnt0_o <= grant_cnt0_o + 1'b1;
      if ( gnt && grant_cnt1_o != '1) grant_cnt1_o <= grant_cnt1_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a transaction-level model.
// Define ALU_ARB_STATS_EN to also check the grant counters.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*OW-1:0] req_op;
  logic [2*DW-1:0] req_a, req_b;
  logic [DW-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic          rsp_zero, busy;
  logic [OW-1:0] alu_op;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] cnt0, cnt1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a | b;
      4'd2:    return a << b[4:0];
      4'd3:    return a >> b[4:0];
      4'd4:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // external combinational ALU
  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)
`ifdef ALU_ARB_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
    .alu_operation_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .busy_o(busy)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0_o(cnt0), .grant_cnt1_o(cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // model: cycles since acceptance (0 = free, 1 = executing, 2 = responding)
  int            since = 0;
  int            owner = 0;
  int            ptr_m = 0;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a, m_b, m_res;
  longint        m_cnt[2];

  task automatic drive(input int cyc);
    logic [OW-1:0] op;
    logic [DW-1:0] a, b;
    reset = (cyc == 300 || cyc == 517 || cyc == 733);
    if (cyc < 40) begin
      req_valid = 2'b11;
      rsp_ready = 2'b11;
    end else if (cyc < 100) begin
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'b00;
    end else if (cyc < 160) begin
      req_valid = 2'b01;
      rsp_ready = 2'b01;
    end else begin
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
    end
    if (reset) req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      op = 4'($urandom_range(0, 5));
      if (op == 4'd5) op = 4'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
      req_op[i*OW +: OW] = op;
      req_a[i*DW +: DW]  = a;
      req_b[i*DW +: DW]  = b;
    end
  endtask

  task automatic check_and_step();
    int g;
    logic [1:0] exp_ready, exp_rv;
    exp_ready = 2'b00;
    exp_rv    = 2'b00;
    g = (req_valid == 2'b11) ? ptr_m : (req_valid[1] ? 1 : 0);
    if (since == 0 && req_valid != 2'b00) exp_ready[g] = 1'b1;
    if (since == 2) exp_rv[owner] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("busy", 64'(busy), 64'(since != 0));
    chk("alu_op", 64'(alu_op), (since == 1) ? 64'(m_op) : 64'd0);
    chk("alu_a", 64'(alu_a), (since == 1) ? 64'(m_a) : 64'd0);
    chk("alu_b", 64'(alu_b), (since == 1) ? 64'(m_b) : 64'd0);
    if (since == 2) begin
      chk("result", 64'(rsp_result), 64'(m_res));
      chk("zero", 64'(rsp_zero), 64'(m_res == 0));
    end else begin
      chk("zero_idle", 64'(rsp_zero), 64'd0);
    end
`ifdef ALU_ARB_STATS_EN
    chk("cnt0", 64'(cnt0), 64'(m_cnt[0]));
    chk("cnt1", 64'(cnt1), 64'(m_cnt[1]));
`endif
    if (reset) begin
      since = 0; ptr_m = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (since == 0) begin
      if (req_valid != 2'b00) begin
        owner = g;
        m_op  = req_op[g*OW +: OW];
        m_a   = req_a[g*DW +: DW];
        m_b   = req_b[g*DW +: DW];
        m_res = alu_f(m_op, m_a, m_b);
        if (m_cnt[g] < (64'd1 << CW) - 1) m_cnt[g]++;
        since = 1;
      end
    end else if (since == 1) begin
      since = 2;
    end else if (rsp_ready[owner]) begin
      since = 0;
      ptr_m = 1 - owner;
    end
  endtask

  initial begin
    m_cnt[0] = 0; m_cnt[1] = 0;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk);
        #1;
      end
      drive(cyc);
      @(negedge clk);
      check_and_step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
